// File: rtl/psec6_readout_sequencer_pkg.sv
// Shared types and constants for the PSEC6 readout sequencer.
package psec6_readout_sequencer_pkg;

  localparam int unsigned RDSEQ_NUM_SEL = 6;
  localparam int unsigned RDSEQ_SEL_W   = 3;

  localparam logic [RDSEQ_SEL_W-1:0] RDSEQ_SEL_TRIGCNT = 3'd0;
  localparam logic [RDSEQ_SEL_W-1:0] RDSEQ_SEL_CA      = 3'd1;
  localparam logic [RDSEQ_SEL_W-1:0] RDSEQ_SEL_CB      = 3'd2;
  localparam logic [RDSEQ_SEL_W-1:0] RDSEQ_SEL_CC      = 3'd3;
  localparam logic [RDSEQ_SEL_W-1:0] RDSEQ_SEL_CD      = 3'd4;
  localparam logic [RDSEQ_SEL_W-1:0] RDSEQ_SEL_CE      = 3'd5;

  typedef enum logic [2:0] {
    RDSEQ_IDLE    = 3'd0,
    RDSEQ_LOAD    = 3'd1,
    RDSEQ_SHIFT   = 3'd2,
    RDSEQ_PRESENT = 3'd3,
    RDSEQ_DONE    = 3'd4
  } rdseq_state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned rdseq_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psec6_readout_sequencer_if.sv
// Valid/ready readout word port of the PSEC6 readout sequencer.
interface psec6_readout_sequencer_if
  import psec6_readout_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned WORD_W = 10
);
  localparam int unsigned CH_W = rdseq_idx_w(NUM_CH);

  logic [WORD_W-1:0]      rd_data;
  logic [CH_W-1:0]        rd_ch;
  logic [RDSEQ_SEL_W-1:0] rd_reg;
  logic                   rd_valid;
  logic                   rd_ready;

  modport master (
    output rd_data, rd_ch, rd_reg, rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data, rd_ch, rd_reg, rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/psec6_readout_sequencer_deserializer.sv
// Serial-to-parallel capture for one readout word, MSB first.
// The oldest WORD_W-1 bits are stored; the full word is formed with the
// bit arriving this cycle so the caller can register it on the last shift.
module psec6_readout_sequencer_deserializer #(
  parameter int unsigned WORD_W = 10
) (
  input  logic              SPI_CLK,
  input  logic              RSTB,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              din,
  output logic [WORD_W-1:0] word_c,
  output logic              last_c
);
  localparam int unsigned SR_W  = WORD_W - 1;
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic [SR_W-1:0]  sr_q;
  logic [CNT_W-1:0] cnt_q;

  assign word_c = {sr_q, din};
  assign last_c = (cnt_q == CNT_W'(WORD_W - 1));

  // Shift register and bit counter.
  always_ff @(posedge SPI_CLK) begin
    if (!RSTB) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= word_c[SR_W-1:0];
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/psec6_readout_sequencer.sv
// PSEC6 readout sequencer: walks channels and register selects, loads each
// channel, deserializes its count word and presents it on a valid/ready port.
// Optional: PSEC6_READOUT_SKIP_EMPTY_EN skips selects 1..5 of a channel whose
// trigger count word reads zero.
module psec6_readout_sequencer
  import psec6_readout_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned WORD_W = 10
) (
  input  logic                   SPI_CLK,
  input  logic                   RSTB,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_CH-1:0]      INST_READOUT,
  output logic [RDSEQ_SEL_W-1:0] SELECT_REG,
  input  logic [NUM_CH-1:0]      CNT_SER,
  psec6_readout_sequencer_if.master rd
);
  localparam int unsigned CH_W = rdseq_idx_w(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  rdseq_state_t           state_q, state_nxt;
  logic [CH_W-1:0]        ch_q, ch_nxt;
  logic [RDSEQ_SEL_W-1:0] sel_q, sel_nxt;

  logic                   busy_nxt, done_nxt, valid_nxt;
  logic [NUM_CH-1:0]      inst_nxt;
  logic [RDSEQ_SEL_W-1:0] sel_out_nxt;
  logic [WORD_W-1:0]      rd_data_q, rd_data_nxt;
  logic [CH_W-1:0]        rd_ch_q, rd_ch_nxt;
  logic [RDSEQ_SEL_W-1:0] rd_reg_q, rd_reg_nxt;
  logic                   rd_valid_q;

  logic                   des_clr, des_shift, des_last, capture;
  logic [WORD_W-1:0]      des_word;
  logic                   skip_c;

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_ch    = rd_ch_q;
  assign rd.rd_reg   = rd_reg_q;
  assign rd.rd_valid = rd_valid_q;

  psec6_readout_sequencer_deserializer #(.WORD_W(WORD_W)) u_deser (
    .SPI_CLK  (SPI_CLK),
    .RSTB     (RSTB),
    .clr      (des_clr),
    .shift_en (des_shift),
    .din      (CNT_SER[ch_q]),
    .word_c   (des_word),
    .last_c   (des_last)
  );

`ifdef PSEC6_READOUT_SKIP_EMPTY_EN
  // A zero trigger count means the channel has nothing else worth reading.
  assign skip_c = (sel_q == RDSEQ_SEL_TRIGCNT) && (rd_data_q[2:0] == 3'd0);
`else
  assign skip_c = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state_q;
    ch_nxt    = ch_q;
    sel_nxt   = sel_q;
    des_clr   = 1'b0;
    des_shift = 1'b0;
    capture   = 1'b0;

    unique case (state_q)
      RDSEQ_IDLE: begin
        if (start) begin
          state_nxt = RDSEQ_LOAD;
          ch_nxt    = '0;
          sel_nxt   = RDSEQ_SEL_TRIGCNT;
        end
      end
      RDSEQ_LOAD: begin
        des_clr   = 1'b1;
        state_nxt = RDSEQ_SHIFT;
      end
      RDSEQ_SHIFT: begin
        des_shift = 1'b1;
        if (des_last) begin
          capture   = 1'b1;
          state_nxt = RDSEQ_PRESENT;
        end
      end
      RDSEQ_PRESENT: begin
        if (rd.rd_ready) begin
          if ((sel_q < RDSEQ_SEL_CE) && !skip_c) begin
            sel_nxt   = sel_q + 3'd1;
            state_nxt = RDSEQ_LOAD;
          end else if (ch_q < LAST_CH) begin
            ch_nxt    = ch_q + CH_W'(1);
            sel_nxt   = RDSEQ_SEL_TRIGCNT;
            state_nxt = RDSEQ_LOAD;
          end else begin
            state_nxt = RDSEQ_DONE;
          end
        end
      end
      RDSEQ_DONE: state_nxt = RDSEQ_IDLE;
      default:    state_nxt = RDSEQ_IDLE;
    endcase

    busy_nxt    = (state_nxt != RDSEQ_IDLE);
    done_nxt    = (state_nxt == RDSEQ_DONE);
    valid_nxt   = (state_nxt == RDSEQ_PRESENT);
    inst_nxt    = (state_nxt == RDSEQ_LOAD) ? (NUM_CH'(1) << ch_nxt) : '0;
    sel_out_nxt = (state_nxt inside {RDSEQ_LOAD, RDSEQ_SHIFT, RDSEQ_PRESENT})
                  ? sel_nxt : RDSEQ_SEL_TRIGCNT;
    rd_data_nxt = capture ? des_word : rd_data_q;
    rd_ch_nxt   = capture ? ch_q     : rd_ch_q;
    rd_reg_nxt  = capture ? sel_q    : rd_reg_q;
  end

  // State, walk position and registered outputs.
  always_ff @(posedge SPI_CLK) begin
    if (!RSTB) begin
      state_q      <= RDSEQ_IDLE;
      ch_q         <= '0;
      sel_q        <= RDSEQ_SEL_TRIGCNT;
      busy         <= 1'b0;
      done         <= 1'b0;
      INST_READOUT <= '0;
      SELECT_REG   <= RDSEQ_SEL_TRIGCNT;
      rd_data_q    <= '0;
      rd_ch_q      <= '0;
      rd_reg_q     <= RDSEQ_SEL_TRIGCNT;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      ch_q         <= ch_nxt;
      sel_q        <= sel_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      INST_READOUT <= inst_nxt;
      SELECT_REG   <= sel_out_nxt;
      rd_data_q    <= rd_data_nxt;
      rd_ch_q      <= rd_ch_nxt;
      rd_reg_q     <= rd_reg_nxt;
      rd_valid_q   <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_psec6_readout_sequencer.sv
// Self-checking bench for psec6_readout_sequencer (NUM_CH=4, WORD_W=10).
module tb_psec6_readout_sequencer;
  import psec6_readout_sequencer_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WORD_W = 10;

  logic              SPI_CLK = 1'b0;
  logic              RSTB;
  logic              start;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] INST_READOUT;
  logic [2:0]        SELECT_REG;
  logic [NUM_CH-1:0] CNT_SER;

  psec6_readout_sequencer_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) rif ();

  psec6_readout_sequencer #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) dut (
    .SPI_CLK      (SPI_CLK),
    .RSTB         (RSTB),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .INST_READOUT (INST_READOUT),
    .SELECT_REG   (SELECT_REG),
    .CNT_SER      (CNT_SER),
    .rd           (rif)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  typedef struct {
    logic [WORD_W-1:0] data;
    int unsigned       ch;
    int unsigned       sel;
  } word_t;

  // mode: 0 ready high, 1 random ready, 2 20-cycle stall, 3 abort by reset
  typedef struct {
    logic [NUM_CH-1:0][2:0] cnt;
    int                     mode;
    int                     words_full;
    int                     words_skip;
    bit                     timing;
  } frame_vec_t;

  int checks = 0;
  int errors = 0;

  word_t             exp_q[$];
  logic [WORD_W-1:0] pat [NUM_CH][RDSEQ_NUM_SEL];
  logic [WORD_W-1:0] sr [NUM_CH];
  int                bits_left [NUM_CH];
  frame_vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Channel block model: loaded by its INST_READOUT pulse, then shifts the
  // selected word MSB first starting in the cycle after the load; idle
  // channels drive random noise.
  always @(negedge SPI_CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (INST_READOUT[c]) begin
        sr[c] = (SELECT_REG < 3'd6) ? pat[c][SELECT_REG] : '0;
        bits_left[c] = WORD_W;
      end else if (bits_left[c] > 0) begin
        CNT_SER[c] = sr[c][WORD_W-1];
        sr[c] = sr[c] << 1;
        bits_left[c]--;
      end else begin
        CNT_SER[c] = 1'($urandom);
      end
    end
  end

  task automatic run_frame(input frame_vec_t v);
    int  words = 0;
    int  stall = 0;
    int  exp_words;
    bit  finished = 0;
    bit  saw_done = 0;
    bit  skip_en;
    int  cyc;

`ifdef PSEC6_READOUT_SKIP_EMPTY_EN
    skip_en = 1'b1;
    exp_words = v.words_skip;
`else
    skip_en = 1'b0;
    exp_words = v.words_full;
`endif

    // Reference: channels in order, selects 0..5, empty channels truncated.
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < RDSEQ_NUM_SEL; s++)
        pat[c][s] = (s == 0) ? WORD_W'(v.cnt[c]) : WORD_W'($urandom);
    if (v.timing) pat[0][0] = 10'h2A5;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < RDSEQ_NUM_SEL; s++) begin
        if (skip_en && s > 0 && pat[c][0][2:0] == 3'd0) break;
        exp_q.push_back('{data: pat[c][s], ch: c, sel: s});
      end
    end

    @(negedge SPI_CLK);
    start = 1'b1;
    rif.rd_ready = (v.mode != 2);

    for (cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      @(negedge SPI_CLK);
      if (cyc == 1) start = 1'b0;

      if (INST_READOUT !== '0) begin
        if (exp_q.size() == 0) check("load_extra", 32'(INST_READOUT), 32'd0);
        else begin
          check("load_ch", 32'(INST_READOUT), 32'd1 << exp_q[0].ch);
          check("load_sel", 32'(SELECT_REG), exp_q[0].sel);
          check("load_valid_low", 32'(rif.rd_valid), 32'd0);
        end
      end

      if (v.timing) begin
        case (cyc)
          1: check("t_load_c1", 32'(INST_READOUT), 32'd1);
          2: begin
            check("t_load_c2", 32'(INST_READOUT), 32'd0);
            check("t_sel_c2", 32'(SELECT_REG), 32'd0);
            check("t_busy_c2", 32'(busy), 32'd1);
          end
          11: check("t_valid_c11", 32'(rif.rd_valid), 32'd0);
          12: begin
            check("t_valid_c12", 32'(rif.rd_valid), 32'd1);
            check("t_data_c12", 32'(rif.rd_data), 32'h2A5);
            check("t_ch_c12", 32'(rif.rd_ch), 32'd0);
            check("t_reg_c12", 32'(rif.rd_reg), 32'd0);
          end
          default: ;
        endcase
      end

      if (v.mode == 3) begin
        if (cyc == 5) start = 1'b1;
        if (cyc == 6) begin
          start = 1'b0;
          check("start_ignored", 32'(INST_READOUT), 32'd0);
        end
        if (cyc == 12) check("abort_first_valid", 32'(rif.rd_valid), 32'd1);
        if (cyc == 78) RSTB = 1'b0;
        if (cyc == 79) begin
          RSTB = 1'b1;
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_valid", 32'(rif.rd_valid), 32'd0);
          check("abort_inst", 32'(INST_READOUT), 32'd0);
          check("abort_sel", 32'(SELECT_REG), 32'd0);
          check("abort_words", words, exp_words);
          finished = 1;
        end
      end

      if (rif.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) check("word_extra", 32'd1, 32'd0);
        else begin
          check("word_data", 32'(rif.rd_data), 32'(exp_q[0].data));
          check("word_ch", 32'(rif.rd_ch), exp_q[0].ch);
          check("word_reg", 32'(rif.rd_reg), exp_q[0].sel);
        end
      end

      case (v.mode)
        1: rif.rd_ready = 1'($urandom_range(0, 1));
        2: begin
          if (stall < 20) begin
            rif.rd_ready = 1'b0;
            if (rif.rd_valid === 1'b1) stall++;
          end else begin
            if (rif.rd_ready == 1'b0) check("stall_words", words, 0);
            rif.rd_ready = 1'b1;
          end
        end
        default: rif.rd_ready = 1'b1;
      endcase

      if (rif.rd_valid === 1'b1 && rif.rd_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        words++;
      end

      if (done === 1'b1) begin
        saw_done = 1;
        if (v.mode == 0) check("done_cycle", cyc, 12 * exp_words + 1);
        check("frame_words", words, exp_words);
        check("done_busy", 32'(busy), 32'd1);
        finished = 1;
      end
    end

    if (!finished) check("frame_timeout", 32'd0, 32'd1);

    if (v.mode == 3) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge SPI_CLK);
        if (done === 1'b1) saw_done = 1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
    end else begin
      @(negedge SPI_CLK);
      check("done_pulse_width", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    rif.rd_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{cnt: {3'd3, 3'd3, 3'd3, 3'd3}, mode: 0, words_full: 24, words_skip: 24, timing: 1};
    vecs[1] = '{cnt: {3'd3, 3'd3, 3'd0, 3'd3}, mode: 0, words_full: 24, words_skip: 19, timing: 0};
    vecs[2] = '{cnt: {3'd0, 3'd0, 3'd0, 3'd0}, mode: 0, words_full: 24, words_skip: 4,  timing: 0};
    vecs[3] = '{cnt: {3'd5, 3'd0, 3'd1, 3'd7}, mode: 1, words_full: 24, words_skip: 19, timing: 0};
    vecs[4] = '{cnt: {3'd6, 3'd4, 3'd2, 3'd0}, mode: 2, words_full: 24, words_skip: 19, timing: 0};
    vecs[5] = '{cnt: {3'd3, 3'd3, 3'd3, 3'd3}, mode: 3, words_full: 6,  words_skip: 6,  timing: 0};
    vecs[6] = '{cnt: {3'd1, 3'd2, 3'd3, 3'd4}, mode: 0, words_full: 24, words_skip: 24, timing: 0};

    RSTB = 1'b0;
    start = 1'b0;
    rif.rd_ready = 1'b0;
    repeat (3) @(posedge SPI_CLK);
    @(negedge SPI_CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_inst", 32'(INST_READOUT), 32'd0);
    check("rst_sel", 32'(SELECT_REG), 32'd0);
    check("rst_data", 32'(rif.rd_data), 32'd0);
    check("rst_ch", 32'(rif.rd_ch), 32'd0);
    check("rst_reg", 32'(rif.rd_reg), 32'd0);
    check("rst_valid", 32'(rif.rd_valid), 32'd0);
    RSTB = 1'b1;
    repeat (2) @(negedge SPI_CLK);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psec6_readout_sequencer.md
# psec6_readout_sequencer

Chip-level SPI-clock-domain controller that drains captured timestamp and trigger-count data from all PSEC6 channel digital blocks after sampling stops. Walks channels in ascending order; for each, walks the register selects (trigger count, then CA..CE). For each select it pulses that channel's readout load, deserializes the channel's 10-bit serial count output, and presents the word on a valid/ready port. Shares one SELECT_REG bus across all channels and grants readout to exactly one channel at a time.

## Interface
Parameters:
- NUM_CH, 8, number of channel digital blocks sequenced (≥1)
- WORD_W, 10, serial word width per select

Ports:
- SPI_CLK  input  1  40 MHz SPI clock; the only clock
- RSTB  input  1  reset; synchronous, active-low
- start  input  1  begin a readout frame; sampled only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the frame completes
- INST_READOUT  output  NUM_CH  one-hot load pulse to the granted channel
- SELECT_REG  output  3  shared register select to all channels
- CNT_SER  input  NUM_CH  serial data from each channel, MSB first
- rd_data  output  WORD_W  deserialized word
- rd_ch  output  $clog2(NUM_CH) (min 1)  channel index of rd_data
- rd_reg  output  3  select code of rd_data
- rd_valid  output  1  rd_data/rd_ch/rd_reg valid
- rd_ready  input  1  consumer accepts the word when rd_valid & rd_ready

## Operation
- Select codes: 0 = trigger count (3 bits, right-aligned, upper bits zero), 1..5 = CA, CB, CC, CD, CE.
- States: IDLE, LOAD, SHIFT, PRESENT, DONE.
- IDLE: outputs quiet; start=1 → LOAD with ch=0, reg=0.
- LOAD (1 cycle): INST_READOUT[ch]=1, SELECT_REG=reg → SHIFT, bit counter cleared.
- SHIFT (WORD_W cycles): each cycle shift CNT_SER[ch] into the LSB of the capture register; after WORD_W bits → PRESENT. SELECT_REG holds reg; INST_READOUT all zero.
- PRESENT: rd_valid=1, rd_data/rd_ch/rd_reg held stable until handshake. On handshake: if reg<5, reg+1 → LOAD; else if ch<NUM_CH-1, ch+1, reg=0 → LOAD; else → DONE.
- DONE (1 cycle): done=1 → IDLE.
- start outside IDLE is ignored; no queuing.
- Only the granted channel's CNT_SER is sampled; other inputs are don't-care.
- rd_ready low in PRESENT stalls indefinitely with no data loss; rd_ready outside PRESENT is ignored.

## Timing
- Reset values: busy=0, done=0, INST_READOUT=0, SELECT_REG=0, rd_data=0, rd_ch=0, rd_reg=0, rd_valid=0; state IDLE, ch=0, reg=0.
- RSTB low at any edge, including mid-frame, returns to IDLE on that edge. The partial frame is discarded and no done pulse is issued.
- start high at edge 0 → LOAD in cycle 1 → SHIFT in cycles 2..11 → rd_valid first high in cycle 12.
- No-stall cost: 12 cycles per word. Full frame: NUM_CH×72 cycles. done is high in the cycle after the final handshake.
- Next LOAD begins in the cycle after a handshake. rd_valid drops in that same cycle.
- All outputs are registered.

## Configuration
- PSEC6_READOUT_SKIP_EMPTY_EN defined: on handshake of a reg=0 word whose rd_data[2:0]==0, skip selects 1..5. The sequencer advances to the next channel (or DONE if it was the last). An empty channel then costs 12 cycles.
- Undefined: every channel always yields 6 words regardless of count.

## Structure
- Shared package (types_pkg) gains:
  - rdseq_state_t enum
  - constants: RDSEQ_NUM_SEL=6, RDSEQ_SEL_TRIGCNT=3'd0, RDSEQ_SEL_CA=3'd1 … RDSEQ_SEL_CE=3'd5
- Sub-module readout_deserializer: WORD_W shift register plus bit counter, with clear and shift-enable inputs and a last-bit flag. The sequencer FSM instantiates one.

## Test plan
- Reset/idle: hold RSTB=0 three cycles → every output at its reset value; busy=0.
- Single word timing: NUM_CH=2, start at cycle 0, channel 0 serializes 10'h2A5 MSB first from cycle 2 → INST_READOUT=2'b01 in cycle 1 only, rd_valid in cycle 12 with rd_data=10'h2A5, rd_ch=0, rd_reg=0.
- Full frame ordering: NUM_CH=4, rd_ready tied high, distinct per-channel/per-select patterns → 24 words in order (ch0 reg0..5, ch1 …), done pulse at cycle 289.
- Backpressure: rd_ready low for 20 cycles in PRESENT → rd_valid and data stable; no next LOAD until the handshake; word count unchanged.
- Mid-frame reset and ignored start: start pulsed in SHIFT is ignored; RSTB low in SHIFT of ch1 → IDLE next edge, no done. A new start then restarts at ch=0, reg=0.
- Skip-empty (macro defined): channel 1 count=0, others count=3 → channel 1 yields one word, total words 6×(NUM_CH-1)+1. With the macro undefined → 6×NUM_CH.
